// File: rtl/darc_axil_regtest_master.sv
// darc_axil_regtest_master: AXI4-Lite write/read-back register sequencer.
// Writes NUM_REGS words starting at BASE_ADDR, reads each back, counts mismatches,
// error responses and handshake timeouts, then reports done/pass/err_count.
// Optional feature macro: DARC_REGTEST_LFSR_EN selects a 32-bit Galois LFSR data
// pattern; when undefined the pattern is SEED + index.
module darc_axil_regtest_master #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 4,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          ADDR_STRIDE = 4,
    parameter logic [31:0]          SEED        = 32'h0101FFFF,
    parameter int unsigned          TIMEOUT     = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [ADDR_W-1:0]       M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_W-1:0]       M_AXI_WDATA,
    output logic [DATA_W/8-1:0]     M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_W-1:0]       M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_W-1:0]       M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned IDX_W = 8;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [1:0]       RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;

    logic                tmo;
    logic                abort;
    logic                err_inc;
    logic                finish;

    // Next data word of the test pattern
    function automatic logic [31:0] next_word(input logic [31:0] w);
`ifdef DARC_REGTEST_LFSR_EN
        next_word = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
`else
        next_word = w + 32'd1;
`endif
    endfunction

    // Saturating error counter increment
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        index_d   = index_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        abort     = 1'b0;
        err_inc   = 1'b0;
        finish    = 1'b0;
        tmo       = (timer_q == TMO_LAST);

        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d   = ST_WR;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    index_d   = '0;
                    addr_d    = BASE_ADDR;
                    data_d    = SEED;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            ST_WR: begin
                // Each channel drops its VALID on its own READY
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            ST_WB: begin
                if (M_AXI_BVALID) begin
                    bready_d  = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = ST_RA;
                    err_inc   = (M_AXI_BRESP != RESP_OKAY);
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            ST_RA: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            ST_RD: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    data_d   = next_word(data_q);
                    err_inc  = (M_AXI_RDATA != DATA_W'(data_q)) || (M_AXI_RRESP != RESP_OKAY);
                    if (index_q == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        index_d   = index_q + IDX_W'(1);
                        addr_d    = addr_q + ADDR_W'(ADDR_STRIDE);
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout abort: count it and withdraw every outstanding request
        if (abort) begin
            err_inc   = 1'b1;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            finish    = 1'b1;
        end

        if (err_inc) begin
            err_d = sat_inc(err_q);
        end

        if (finish) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
        end

        // Timer counts cycles spent in the current handshake state
        if (busy_q && (state_d == state_q)) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            index_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            index_q   <= index_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = DATA_W'(data_q);
    assign M_AXI_WSTRB   = {(DATA_W/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
